// File: rtl/lif_neuron_serial_if.sv
// Handshake, configuration and weight-load bus between a layer controller and one
// lif_neuron_serial instance.
interface lif_neuron_serial_if #(
    parameter int N_IN         = 784,
    parameter int WEIGHT_WIDTH = 32,
    parameter int POTENT_WIDTH = 48
);
    localparam int AW = (N_IN > 1) ? $clog2(N_IN) : 1;

    logic                    cfg_wen;
    logic [1:0]              cfg_addr;
    logic [POTENT_WIDTH-1:0] cfg_wdata;
    logic                    w_wen;
    logic [AW-1:0]           w_addr;
    logic [WEIGHT_WIDTH-1:0] w_wdata;
    logic                    start;
    logic [N_IN-1:0]         spike_in;
    logic                    busy;
    logic                    done;
    logic                    spike_out;
    logic [POTENT_WIDTH-1:0] potent_out;

    modport master (
        output cfg_wen, cfg_addr, cfg_wdata, w_wen, w_addr, w_wdata, start, spike_in,
        input  busy, done, spike_out, potent_out
    );

    modport slave (
        input  cfg_wen, cfg_addr, cfg_wdata, w_wen, w_addr, w_wdata, start, spike_in,
        output busy, done, spike_out, potent_out
    );
endinterface

// File: rtl/lif_neuron_serial.sv
// Time-multiplexed leaky integrate-and-fire neuron: accumulates LANES weights per cycle,
// then applies leak, threshold and refractory logic once per timestep.
module lif_neuron_serial #(
    parameter int                      N_IN           = 784,
    parameter int                      LANES          = 4,
    parameter int                      WEIGHT_WIDTH   = 32,
    parameter int                      POTENT_WIDTH   = 48,
    parameter int                      REFRAC_WIDTH   = 4,
    parameter logic [POTENT_WIDTH-1:0] THRESH_DEFAULT = 48'h000600000000,
    parameter logic [POTENT_WIDTH-1:0] REST_DEFAULT   = 48'h000280000000,
    parameter int                      LEAK_DEFAULT   = 0,
    parameter int                      REFRAC_DEFAULT = 1
) (
    input  logic              clk,
    input  logic              rst,
    lif_neuron_serial_if.slave bus
);
    localparam int PW = POTENT_WIDTH;
    localparam int WW = WEIGHT_WIDTH;
    localparam int AW = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int IW = $clog2(N_IN + LANES) + 1;
    localparam logic signed [PW-1:0] SMAX = {1'b0, {(PW-1){1'b1}}};
    localparam logic signed [PW-1:0] SMIN = {1'b1, {(PW-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_UPDATE} state_t;

    state_t                   r_state, w_state_nxt;
    logic signed [WW-1:0]     r_wmem [N_IN];
    logic [N_IN-1:0]          r_shadow;
    logic [IW-1:0]            r_idx;
    logic signed [PW-1:0]     r_sum;
    logic signed [PW-1:0]     r_potent;
    logic signed [PW-1:0]     r_thresh;
    logic signed [PW-1:0]     r_rest;
    logic [5:0]               r_leak;
    logic [REFRAC_WIDTH-1:0]  r_refrac_len;
    logic [REFRAC_WIDTH-1:0]  r_refrac_cnt;
    logic                     r_done;
    logic                     r_spike;

    logic                     w_idle;
    logic                     w_last;
    logic signed [PW-1:0]     w_lane_sum;
    logic signed [PW-1:0]     w_leak;
    logic signed [PW-1:0]     w_v;

    function automatic logic signed [PW-1:0] sat_add(input logic signed [PW-1:0] a,
                                                     input logic signed [PW-1:0] b);
        logic signed [PW:0] s;
        s = {a[PW-1], a} + {b[PW-1], b};
        if (s[PW] != s[PW-1]) return s[PW] ? SMIN : SMAX;
        return s[PW-1:0];
    endfunction

    function automatic logic signed [PW-1:0] sext(input logic signed [WW-1:0] w);
        return {{(PW-WW){w[WW-1]}}, w};
    endfunction

    assign w_idle = (r_state == S_IDLE);
    assign w_last = (int'(r_idx) + LANES >= N_IN);

    always_comb begin
        int            k;
        logic [AW-1:0] ka;
        k          = 0;
        ka         = '0;
        w_lane_sum = r_sum;
        for (int l = 0; l < LANES; l++) begin
            k = int'(r_idx) + l;
            if (k < N_IN) begin
                ka = k[AW-1:0];
                if (r_shadow[ka]) w_lane_sum = sat_add(w_lane_sum, sext(r_wmem[ka]));
            end
        end
    end

    // potent - (potent >>> s) keeps the sign of potent, so only the final add can overflow
    assign w_leak = (r_leak == 6'd0) ? '0 : (r_potent >>> r_leak);
    assign w_v    = sat_add(r_potent - w_leak, r_sum);

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (bus.start) w_state_nxt = S_ACCUM;
            S_ACCUM:  if (w_last)    w_state_nxt = S_UPDATE;
            S_UPDATE: w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst && w_idle && bus.w_wen && int'(bus.w_addr) < N_IN)
            r_wmem[bus.w_addr] <= bus.w_wdata;
    end

    always_ff @(posedge clk) begin
        if (w_idle && bus.start) begin
            r_shadow <= bus.spike_in;
            r_idx    <= '0;
            r_sum    <= '0;
        end else if (r_state == S_ACCUM) begin
            r_sum <= w_lane_sum;
            r_idx <= r_idx + IW'(LANES);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_potent     <= REST_DEFAULT;
            r_thresh     <= THRESH_DEFAULT;
            r_rest       <= REST_DEFAULT;
            r_leak       <= 6'(LEAK_DEFAULT);
            r_refrac_len <= REFRAC_WIDTH'(REFRAC_DEFAULT);
            r_refrac_cnt <= '0;
            r_done       <= 1'b0;
            r_spike      <= 1'b0;
        end else begin
            r_done  <= 1'b0;
            r_spike <= 1'b0;
            if (w_idle && bus.cfg_wen) begin
                case (bus.cfg_addr)
                    2'd0:    r_thresh     <= bus.cfg_wdata;
                    2'd1:    r_rest       <= bus.cfg_wdata;
                    2'd2:    r_leak       <= bus.cfg_wdata[5:0];
                    default: r_refrac_len <= bus.cfg_wdata[REFRAC_WIDTH-1:0];
                endcase
            end
            if (r_state == S_UPDATE) begin
                r_done <= 1'b1;
                if (r_refrac_cnt != '0) begin
                    r_refrac_cnt <= r_refrac_cnt - REFRAC_WIDTH'(1);
                end else if (w_v >= r_thresh) begin
                    r_spike      <= 1'b1;
                    r_potent     <= r_rest;
                    r_refrac_cnt <= r_refrac_len;
                end else begin
                    r_potent <= w_v;
                end
            end
        end
    end

    assign bus.busy       = !w_idle;
    assign bus.done       = r_done;
    assign bus.spike_out  = r_spike;
    assign bus.potent_out = r_potent;
endmodule
